// File: rtl/eq_scale_sched_if.sv
// Frame-level bus between the EQ band filters/control and eq_scale_sched.
// Handshake: start is a one-cycle request taken only while busy is low; out_vld is a one-cycle strobe with no back-pressure.
interface eq_scale_sched_if;
  logic               start;
  logic signed [15:0] LP_lftOut, B1_lftOut, B2_lftOut, B3_lftOut, HP_lftOut;
  logic signed [15:0] LP_rhtOut, B1_rhtOut, B2_rhtOut, B3_rhtOut, HP_rhtOut;
  logic        [11:0] LP_gain, B1_gain, B2_gain, B3_gain, HP_gain;
  logic        [11:0] volume;
  logic               busy;
  logic               out_vld;
  logic               overrun;
  logic signed [15:0] lft_out;
  logic signed [15:0] rht_out;

  modport master (
    output start,
    output LP_lftOut, B1_lftOut, B2_lftOut, B3_lftOut, HP_lftOut,
    output LP_rhtOut, B1_rhtOut, B2_rhtOut, B3_rhtOut, HP_rhtOut,
    output LP_gain, B1_gain, B2_gain, B3_gain, HP_gain,
    output volume,
    input  busy, out_vld, overrun, lft_out, rht_out
  );

  modport slave (
    input  start,
    input  LP_lftOut, B1_lftOut, B2_lftOut, B3_lftOut, HP_lftOut,
    input  LP_rhtOut, B1_rhtOut, B2_rhtOut, B3_rhtOut, HP_rhtOut,
    input  LP_gain, B1_gain, B2_gain, B3_gain, HP_gain,
    input  volume,
    output busy, out_vld, overrun, lft_out, rht_out
  );
endinterface

// File: rtl/eq_scale_sched.sv
// Band-scale / sum / volume scheduler using one shared signed multiplier.
// Optional macro EQ_SCHED_SAT_EN: saturating 16-bit reductions instead of two's-complement wrap.
module eq_scale_sched (
  input  logic                 clk,
  input  logic                 rst,
  eq_scale_sched_if.slave      bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_VOL  = 2'd2
  } state_t;

  state_t state, state_n;
  logic [3:0] step, step_n;

  logic signed [15:0] aud_q [10];
  logic        [11:0] gain_q [5];
  logic        [11:0] vol_q;
  logic signed [19:0] acc_l, acc_r;
  logic signed [15:0] lft_stage;
  logic signed [15:0] lft_q, rht_q;
  logic               out_vld_q, overrun_q;

  logic               busy;
  logic               last_step;
  logic [2:0]         gsel;
  logic signed [15:0] mul_a;
  logic signed [12:0] mul_b;
  logic signed [28:0] prod;
  logic signed [19:0] band_term;
  logic signed [16:0] vol_full;
  logic signed [19:0] acc_sel;
  logic signed [15:0] red;
  logic signed [15:0] vol_res;
  logic               unused_lsbs;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= 4'd0;
    end else begin
      state <= state_n;
      step  <= step_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_MAC;
          step_n  = 4'd0;
        end
      end
      S_MAC: begin
        if (step == 4'd9) begin
          state_n = S_VOL;
          step_n  = 4'd0;
        end else begin
          step_n = step + 4'd1;
        end
      end
      S_VOL: begin
        if (step == 4'd1) begin
          state_n = S_IDLE;
          step_n  = 4'd0;
        end else begin
          step_n = step + 4'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        step_n  = 4'd0;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign last_step = (state == S_VOL) && (step == 4'd1);
  assign dbg_state = state;

  // ---------------- shared multiplier ----------------
  assign gsel = (step >= 4'd5) ? 3'(step - 4'd5) : step[2:0];

  // VOL step 0 works on the left accumulator, step 1 on the right.
  always_comb begin
    acc_sel = step[0] ? acc_r : acc_l;
`ifdef EQ_SCHED_SAT_EN
    if (acc_sel > 20'sd32767)
      red = 16'sh7FFF;
    else if (acc_sel < -20'sd32768)
      red = 16'sh8000;
    else
      red = acc_sel[15:0];
`else
    red = acc_sel[15:0];
`endif
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == S_VOL) begin
      mul_a = red;
      mul_b = {1'b0, vol_q};
    end else begin
      mul_a = aud_q[step];
      mul_b = {1'b0, gain_q[gsel]};
    end
  end

  assign prod      = mul_a * mul_b;
  assign band_term = {{2{prod[28]}}, prod[28:11]};
  assign vol_full  = prod[28:12];

  always_comb begin
`ifdef EQ_SCHED_SAT_EN
    if (vol_full[16] != vol_full[15])
      vol_res = vol_full[16] ? 16'sh8000 : 16'sh7FFF;
    else
      vol_res = vol_full[15:0];
`else
    vol_res = vol_full[15:0];
`endif
  end

`ifdef EQ_SCHED_SAT_EN
  assign unused_lsbs = ^prod[10:0];
`else
  assign unused_lsbs = ^{prod[10:0], vol_full[16], acc_sel[19:16]};
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) aud_q[i] <= '0;
      for (int i = 0; i < 5; i++)  gain_q[i] <= '0;
      vol_q     <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      lft_stage <= '0;
      lft_q     <= '0;
      rht_q     <= '0;
      out_vld_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      out_vld_q <= 1'b0;
      // The final edge still counts as busy, but out_vld owns that cycle.
      overrun_q <= bus.start && busy && !last_step;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            aud_q[0]  <= bus.LP_lftOut;
            aud_q[1]  <= bus.B1_lftOut;
            aud_q[2]  <= bus.B2_lftOut;
            aud_q[3]  <= bus.B3_lftOut;
            aud_q[4]  <= bus.HP_lftOut;
            aud_q[5]  <= bus.LP_rhtOut;
            aud_q[6]  <= bus.B1_rhtOut;
            aud_q[7]  <= bus.B2_rhtOut;
            aud_q[8]  <= bus.B3_rhtOut;
            aud_q[9]  <= bus.HP_rhtOut;
            gain_q[0] <= bus.LP_gain;
            gain_q[1] <= bus.B1_gain;
            gain_q[2] <= bus.B2_gain;
            gain_q[3] <= bus.B3_gain;
            gain_q[4] <= bus.HP_gain;
            vol_q     <= bus.volume;
            acc_l     <= '0;
            acc_r     <= '0;
          end
        end
        S_MAC: begin
          if (step < 4'd5)
            acc_l <= acc_l + band_term;
          else
            acc_r <= acc_r + band_term;
        end
        S_VOL: begin
          if (step == 4'd0) begin
            lft_stage <= vol_res;
          end else begin
            lft_q     <= lft_stage;
            rht_q     <= vol_res;
            out_vld_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.out_vld = out_vld_q;
  assign bus.overrun = overrun_q;
  assign bus.lft_out = lft_q;
  assign bus.rht_out = rht_q;

endmodule

// File: tb/tb_eq_scale_sched.sv
// Directed self-checking bench for eq_scale_sched (expected values hand-computed).
module tb_eq_scale_sched;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  eq_scale_sched_if bus();

  eq_scale_sched dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bands(input logic [15:0] l, input logic [15:0] r,
                           input logic [11:0] g, input logic [11:0] v);
    bus.LP_lftOut = l; bus.B1_lftOut = l; bus.B2_lftOut = l; bus.B3_lftOut = l; bus.HP_lftOut = l;
    bus.LP_rhtOut = r; bus.B1_rhtOut = r; bus.B2_rhtOut = r; bus.B3_rhtOut = r; bus.HP_rhtOut = r;
    bus.LP_gain = g; bus.B1_gain = g; bus.B2_gain = g; bus.B3_gain = g; bus.HP_gain = g;
    bus.volume = v;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    step_clk();
    bus.start = 1'b0;
  endtask

  // Counts cycles after the start edge until out_vld; 30 means it never came.
  task automatic wait_vld(output int cyc);
    cyc = 0;
    while (cyc < 30) begin
      step_clk();
      cyc++;
      if (bus.out_vld === 1'b1) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    set_bands(16'h1234, 16'h4321, 12'h800, 12'h800);
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (3) step_clk();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b expected 0", bus.out_vld); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    n_checks++; if (bus.lft_out !== 16'h0000) begin n_fail++; $display("FAIL reset_lft: got %h expected 0000", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'h0000) begin n_fail++; $display("FAIL reset_rht: got %h expected 0000", bus.rht_out); end
    rst = 1'b0;
    bus.start = 1'b0;
    step_clk();
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_start_ignored: state got %0d expected 0", dbg_state); end
  endtask

  task automatic test_unity;
    int cyc;
    set_bands(16'h0100, 16'hFF00, 12'h800, 12'h800);
    pulse_start();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL unity_busy_after_start: got %b expected 1", bus.busy); end
    wait_vld(cyc);
    n_checks++; if (cyc != 12) begin n_fail++; $display("FAIL unity_latency: got %0d expected 12", cyc); end
    n_checks++; if (bus.lft_out !== 16'h0280) begin n_fail++; $display("FAIL unity_lft: got %h expected 0280", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'hFD80) begin n_fail++; $display("FAIL unity_rht: got %h expected fd80", bus.rht_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL unity_busy_at_vld: got %b expected 0", bus.busy); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL unity_overrun: got %b expected 0", bus.overrun); end
    step_clk();
    n_checks++; if (bus.out_vld !== 1'b0) begin n_fail++; $display("FAIL unity_vld_one_cycle: got %b expected 0", bus.out_vld); end
    n_checks++; if (bus.lft_out !== 16'h0280) begin n_fail++; $display("FAIL unity_lft_held: got %h expected 0280", bus.lft_out); end
  endtask

  task automatic test_band_iso;
    int cyc;
    set_bands(16'h0000, 16'h0000, 12'h000, 12'hFFF);
    bus.B2_lftOut = 16'h4000;
    bus.B2_gain   = 12'h400;
    pulse_start();
    wait_vld(cyc);
    n_checks++; if (cyc != 12) begin n_fail++; $display("FAIL iso_latency: got %0d expected 12", cyc); end
    n_checks++; if (bus.lft_out !== 16'h1FFE) begin n_fail++; $display("FAIL iso_lft: got %h expected 1ffe", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'h0000) begin n_fail++; $display("FAIL iso_rht: got %h expected 0000", bus.rht_out); end
  endtask

  task automatic test_saturation;
    int cyc;
    logic [15:0] exp_l;
`ifdef EQ_SCHED_SAT_EN
    exp_l = 16'h7FF7;
`else
    exp_l = 16'h2FFD;
`endif
    set_bands(16'h7000, 16'h0000, 12'h800, 12'hFFF);
    pulse_start();
    wait_vld(cyc);
    n_checks++; if (bus.lft_out !== exp_l) begin n_fail++; $display("FAIL sat_lft: got %h expected %h", bus.lft_out, exp_l); end
    n_checks++; if (bus.rht_out !== 16'h0000) begin n_fail++; $display("FAIL sat_rht: got %h expected 0000", bus.rht_out); end
  endtask

  task automatic test_overrun_back_to_back;
    int cyc;
    int vld_cyc;
    int ov_cnt;
    int cyc2;
    set_bands(16'h0100, 16'hFF00, 12'h800, 12'h800);
    pulse_start();
    cyc = 0; vld_cyc = 0; ov_cnt = 0;
    while (cyc < 30 && vld_cyc == 0) begin
      if (cyc == 4) begin
        bus.start = 1'b1;
        set_bands(16'h0200, 16'hFF00, 12'h800, 12'h800);
      end
      step_clk();
      bus.start = 1'b0;
      cyc++;
      if (bus.overrun === 1'b1) ov_cnt++;
      if (cyc == 5) begin
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b expected 1", bus.overrun); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b expected 1", bus.busy); end
      end
      if (cyc == 6) begin
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle: got %b expected 0", bus.overrun); end
      end
      if (bus.out_vld === 1'b1) vld_cyc = cyc;
    end
    n_checks++; if (vld_cyc != 12) begin n_fail++; $display("FAIL ovr_latency: got %0d expected 12", vld_cyc); end
    n_checks++; if (ov_cnt != 1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", ov_cnt); end
    n_checks++; if (bus.lft_out !== 16'h0280) begin n_fail++; $display("FAIL ovr_lft: got %h expected 0280", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'hFD80) begin n_fail++; $display("FAIL ovr_rht: got %h expected fd80", bus.rht_out); end
    // Start on the cycle right after out_vld must be accepted.
    pulse_start();
    wait_vld(cyc2);
    n_checks++; if (cyc2 != 12) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 12", cyc2); end
    n_checks++; if (bus.lft_out !== 16'h0500) begin n_fail++; $display("FAIL b2b_lft: got %h expected 0500", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'hFD80) begin n_fail++; $display("FAIL b2b_rht: got %h expected fd80", bus.rht_out); end
  endtask

  task automatic test_input_hold;
    int cyc;
    set_bands(16'h0000, 16'h0000, 12'h000, 12'hFFF);
    bus.B2_lftOut = 16'h4000;
    bus.B2_gain   = 12'h400;
    pulse_start();
    set_bands(16'h7FFF, 16'h8000, 12'hFFF, 12'h001);
    wait_vld(cyc);
    n_checks++; if (cyc != 12) begin n_fail++; $display("FAIL hold_latency: got %0d expected 12", cyc); end
    n_checks++; if (bus.lft_out !== 16'h1FFE) begin n_fail++; $display("FAIL hold_lft: got %h expected 1ffe", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'h0000) begin n_fail++; $display("FAIL hold_rht: got %h expected 0000", bus.rht_out); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int vld_seen;
    set_bands(16'h0100, 16'hFF00, 12'h800, 12'h800);
    pulse_start();
    repeat (5) step_clk();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.lft_out !== 16'h0000) begin n_fail++; $display("FAIL rstmid_lft: got %h expected 0000", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'h0000) begin n_fail++; $display("FAIL rstmid_rht: got %h expected 0000", bus.rht_out); end
    n_checks++; if (bus.out_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld: got %b expected 0", bus.out_vld); end
    vld_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      if (bus.out_vld === 1'b1) vld_seen++;
    end
    n_checks++; if (vld_seen != 0) begin n_fail++; $display("FAIL rstmid_no_vld: got %0d strobes expected 0", vld_seen); end
    pulse_start();
    wait_vld(cyc);
    n_checks++; if (cyc != 12) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d expected 12", cyc); end
    n_checks++; if (bus.lft_out !== 16'h0280) begin n_fail++; $display("FAIL rstmid_next_lft: got %h expected 0280", bus.lft_out); end
    n_checks++; if (bus.rht_out !== 16'hFD80) begin n_fail++; $display("FAIL rstmid_next_rht: got %h expected fd80", bus.rht_out); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    set_bands(16'h0000, 16'h0000, 12'h000, 12'h000);
    test_reset();
    test_unity();
    test_band_iso();
    test_saturation();
    test_overrun_back_to_back();
    test_input_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
